// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the peripheral_spi SPI master.
// Holds the register offsets, STATUS/CTRL bit positions, the FSM state
// encoding and the SoC chip-select decode value.
package spi_pkg;

   // Register offsets (byte addresses on j1_io_addr[3:0], always even)
   localparam logic [3:0] ADDR_TXDATA = 4'h0;
   localparam logic [3:0] ADDR_RXDATA = 4'h2;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CLKDIV = 4'h6;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;

   // STATUS register bit positions
   localparam int STAT_BUSY     = 0;
   localparam int STAT_TX_FULL  = 1;
   localparam int STAT_TX_EMPTY = 2;
   localparam int STAT_RX_EMPTY = 3;
   localparam int STAT_RX_FULL  = 4;
   localparam int STAT_RX_OVF   = 5;
   localparam int STAT_TX_OVF   = 6;

   // CTRL register bit positions
   localparam int CTRL_SS   = 0;
   localparam int CTRL_LOOP = 1;

   // Value of j1_io_addr[15:8] that selects this peripheral in j1soc
   localparam logic [7:0] SPI_CS_DECODE = 8'h72;

   // Transfer sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// spi_fifo: small synchronous FIFO used for the SPI TX and RX byte queues.
// dout always shows the head entry; it is only meaningful when empty=0.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module spi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates their use
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/peripheral_spi.sv
// peripheral_spi: memory-mapped SPI master (Mode 0, MSB first, 8-bit) on
// the J1 I/O bus, with TX/RX FIFOs, programmable SCK divider and a
// software-driven slave select.
// Optional build macro: SPI_LOOPBACK_EN adds CTRL bit1 internal loopback.
//
// Bus protocol: rd and wr are single-cycle strobes qualified by cs. A write
// is consumed on the clk edge where cs&wr=1; read data on d_out is
// combinational while cs&rd=1 and any read side effect (RX pop, clearing
// the sticky overflow flags) happens on the clk edge where cs&rd=1.
// There is no back-pressure: every access completes in its own cycle.
module peripheral_spi
   import spi_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   output logic        sck,
   output logic        mosi,
   input  logic        miso,
   output logic        ss_n,
   output spi_state_e  dbg_state
);

   // Bus decode
   logic bus_rd, bus_wr;
   logic stat_rd;

   // FIFO interfaces
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0] tx_head;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] rx_head;
   logic       tx_drop, rx_drop;

   // Transfer engine state
   spi_state_e  state_q, state_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [15:0] div_val_q, div_val_d;
   logic [15:0] div_cnt_q, div_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;

   // Software-visible registers
   logic [15:0] clkdiv_q, clkdiv_d;
   logic        ss_q, ss_d;
   logic        rx_ovf_q, rx_ovf_d;
   logic        tx_ovf_q, tx_ovf_d;

   logic        busy;
   logic        loop_en;
   logic        sample_in;
   logic [15:0] status;

   assign bus_rd  = cs & rd;
   assign bus_wr  = cs & wr;
   assign stat_rd = bus_rd && (addr == ADDR_STATUS);

   assign tx_push = bus_wr && (addr == ADDR_TXDATA);
   assign tx_pop  = (state_q == ST_LOAD);
   assign rx_push = (state_q == ST_DONE);
   assign rx_pop  = bus_rd && (addr == ADDR_RXDATA);

   // A drop only happens when the FIFO is full and no pop frees a slot
   assign tx_drop = tx_push & tx_full & ~tx_pop;
   assign rx_drop = rx_push & rx_full & ~rx_pop;

   spi_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (d_in[7:0]),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   spi_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_sh_q),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

`ifdef SPI_LOOPBACK_EN
   logic loop_q;

   // Loopback enable bit of CTRL
   always_ff @(posedge clk) begin
      if (!rst) begin
         loop_q <= 1'b0;
      end else if (bus_wr && (addr == ADDR_CTRL)) begin
         loop_q <= d_in[CTRL_LOOP];
      end
   end

   assign loop_en = loop_q;
`else
   assign loop_en = 1'b0;
`endif

   // In loopback the engine hears its own mosi; the pin keeps toggling
   assign sample_in = loop_en ? mosi_q : miso;

   assign busy = (state_q != ST_IDLE) | ~tx_empty;

   // Software register next-state: CLKDIV, CTRL.ss and sticky overflow flags
   always_comb begin
      clkdiv_d = clkdiv_q;
      ss_d     = ss_q;
      if (bus_wr && (addr == ADDR_CLKDIV)) clkdiv_d = d_in;
      if (bus_wr && (addr == ADDR_CTRL))   ss_d     = d_in[CTRL_SS];
      // A new overflow in the same cycle as a STATUS read must not be lost
      rx_ovf_d = (rx_ovf_q & ~stat_rd) | rx_drop;
      tx_ovf_d = (tx_ovf_q & ~stat_rd) | tx_drop;
   end

   // Software register state
   always_ff @(posedge clk) begin
      if (!rst) begin
         clkdiv_q <= DIV_RESET;
         ss_q     <= 1'b1;
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
      end else begin
         clkdiv_q <= clkdiv_d;
         ss_q     <= ss_d;
         rx_ovf_q <= rx_ovf_d;
         tx_ovf_q <= tx_ovf_d;
      end
   end

   // Transfer sequencer: next state and shift datapath
   always_comb begin
      state_d   = state_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      div_val_d = div_val_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      case (state_q)
         ST_IDLE: begin
            if (!tx_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // CLKDIV is captured here so mid-byte writes wait for the next byte
            tx_sh_d   = tx_head;
            mosi_d    = tx_head[7];
            div_val_d = clkdiv_q;
            div_cnt_d = 16'd0;
            bit_cnt_d = 4'd0;
            sck_d     = 1'b0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (div_cnt_q == div_val_q) begin
               div_cnt_d = 16'd0;
               sck_d     = ~sck_q;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (!sck_q) begin
                  // Rising edge: capture the incoming bit
                  rx_sh_d = {rx_sh_q[6:0], sample_in};
               end else begin
                  // Falling edge: advance to the next outgoing bit
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  mosi_d  = tx_sh_q[6];
               end
               if (bit_cnt_q == 4'd15) state_d = ST_DONE;
            end else begin
               div_cnt_d = div_cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
            state_d = tx_empty ? ST_IDLE : ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Transfer sequencer registers; reset aborts any byte in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         tx_sh_q   <= 8'h00;
         rx_sh_q   <= 8'h00;
         div_val_q <= 16'h0000;
         div_cnt_q <= 16'h0000;
         bit_cnt_q <= 4'd0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         div_val_q <= div_val_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
      end
   end

   // STATUS word assembly
   always_comb begin
      status                = 16'h0000;
      status[STAT_BUSY]     = busy;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_TX_EMPTY] = tx_empty;
      status[STAT_RX_EMPTY] = rx_empty;
      status[STAT_RX_FULL]  = rx_full;
      status[STAT_RX_OVF]   = rx_ovf_q;
      status[STAT_TX_OVF]   = tx_ovf_q;
   end

   // Read mux; idle bus reads as zero
   always_comb begin
      d_out = 16'h0000;
      if (bus_rd) begin
         case (addr)
            ADDR_RXDATA: d_out = rx_empty ? 16'h0000 : {8'h00, rx_head};
            ADDR_STATUS: d_out = status;
            ADDR_CLKDIV: d_out = clkdiv_q;
            ADDR_CTRL:   d_out = {14'h0000, loop_en, ss_q};
            default:     d_out = 16'h0000;
         endcase
      end
   end

   assign sck       = sck_q;
   assign mosi      = mosi_q;
   assign ss_n      = ss_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_peripheral_spi.sv
// tb_peripheral_spi: directed + randomized bench for peripheral_spi.
// A bus-level slave model answers on miso and records mosi bytes; the
// expected RX contents are kept in a queue derived from the slave bytes.
// Build with SPI_LOOPBACK_EN defined to also exercise the loopback path.
module tb_peripheral_spi;

   localparam logic [3:0] A_TX   = 4'h0;
   localparam logic [3:0] A_RX   = 4'h2;
   localparam logic [3:0] A_ST   = 4'h4;
   localparam logic [3:0] A_DIV  = 4'h6;
   localparam logic [3:0] A_CTRL = 4'h8;
   localparam logic [3:0] A_BAD  = 4'hA;

   logic        clk;
   logic        rst;
   logic [15:0] d_in;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic        ss_n;
   logic [1:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   // Slave model / mosi monitor
   logic [7:0] slv_q[$];
   logic [7:0] mon_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] exp_tx_q[$];
   logic [7:0] slv_cur;
   logic [7:0] mon_sh;
   int         mon_bits;

   peripheral_spi dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .cs        (cs),
      .addr      (addr),
      .rd        (rd),
      .wr        (wr),
      .d_out     (d_out),
      .sck       (sck),
      .mosi      (mosi),
      .miso      (miso),
      .ss_n      (ss_n),
      .dbg_state (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit
   initial begin
      #3000000;
      $display("FAIL global_timeout: observed no end of test, required end before time limit");
      $fatal(1, "time limit");
   end

   // Mode-0 slave: sample mosi and advance miso on every sck rise
   always @(posedge sck) begin
      mon_sh = {mon_sh[6:0], mosi};
      mon_bits++;
      if (mon_bits == 8) begin
         mon_q.push_back(mon_sh);
         mon_bits = 0;
         slv_cur = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
      end
      miso = slv_cur[7 - mon_bits];
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      #1;
      d = d_out;
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic slave_prime();
      mon_bits = 0;
      slv_cur  = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
      miso     = slv_cur[7];
   endtask

   task automatic check_mon(input string tag, input logic [7:0] exp);
      logic [15:0] obs;
      obs = (mon_q.size() > 0) ? {8'h00, mon_q.pop_front()} : 16'hxxxx;
      check(tag, obs, {8'h00, exp});
   endtask

   // Poll STATUS until not busy; the last STATUS value is returned
   task automatic wait_idle(input int max_cyc, output logic [15:0] st);
      int cyc;
      cyc = 0;
      do begin
         bus_read(A_ST, st);
         cyc++;
      end while (st[0] && cyc < max_cyc);
      check("idle_within_bound", {15'h0, st[0]}, 16'h0000);
   endtask

   initial begin
      logic [15:0] rdat;
      logic [15:0] st;
      logic [7:0]  b;
      int          busy_cyc;
      int          sck_hi;
      int          cyc;
      int          k;
      int          div;

      rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;
      miso = 1'b0; mon_bits = 0; mon_sh = 8'h00; slv_cur = 8'h00;

      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_sck", {15'h0, sck}, 16'h0000);
      check("reset_ss_n", {15'h0, ss_n}, 16'h0001);
      check("reset_mosi", {15'h0, mosi}, 16'h0000);
      check("reset_dout", d_out, 16'h0000);
      rst = 1'b1;
      bus_read(A_ST, rdat);   check("reset_status", rdat, 16'h000C);
      bus_read(A_DIV, rdat);  check("reset_clkdiv", rdat, 16'h0004);
      bus_read(A_CTRL, rdat); check("reset_ctrl", rdat, 16'h0001);
      bus_read(A_RX, rdat);   check("rx_empty_read", rdat, 16'h0000);
      bus_read(A_BAD, rdat);  check("unmapped_read", rdat, 16'h0000);
      bus_write(A_BAD, 16'hFFFF);
      bus_read(A_ST, rdat);   check("unmapped_write_ignored", rdat, 16'h000C);

      // ---------------- CTRL / ss_n ----------------
      bus_write(A_CTRL, 16'h0000);
      #1;
      check("ss_n_low", {15'h0, ss_n}, 16'h0000);
      bus_write(A_CTRL, 16'h0002);
      bus_read(A_CTRL, rdat);
`ifdef SPI_LOOPBACK_EN
      check("ctrl_loop_bit", rdat, 16'h0002);
`else
      check("ctrl_loop_bit", rdat, 16'h0000);
`endif
      bus_write(A_CTRL, 16'h0000);

      // ---------------- basic transfer ----------------
      bus_write(A_DIV, 16'h0000);
      slv_q.push_back(8'h3C);
      slave_prime();
      bus_write(A_TX, 16'h00A5);
      busy_cyc = 0; sck_hi = 0; cyc = 0;
      do begin
         bus_read(A_ST, st);
         if (sck) sck_hi++;
         if (st[0]) busy_cyc++;
         cyc++;
      end while (st[0] && cyc < 200);
      check("basic_busy_cycles", 16'(busy_cyc), 16'd19);
      check("basic_sck_high_cycles", 16'(sck_hi), 16'd8);
      check_mon("basic_mosi_byte", 8'hA5);
      bus_read(A_RX, rdat);   check("basic_rxdata", rdat, 16'h003C);
      bus_read(A_ST, rdat);   check("basic_status_after", rdat, 16'h000C);
      #1;
      check("dout_idle_zero", d_out, 16'h0000);

      // ---------------- randomized batches ----------------
      for (int batch = 0; batch < 4; batch++) begin
         div = $urandom_range(0, 3);
         k   = $urandom_range(1, 4);
         bus_write(A_DIV, 16'(div));
         for (int i = 0; i < k; i++) begin
            b = 8'($urandom_range(0, 255));
            slv_q.push_back(b);
            exp_q.push_back(b);
         end
         slave_prime();
         for (int i = 0; i < k; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_tx_q.push_back(b);
            bus_write(A_TX, {8'h00, b});
         end
         wait_idle(4 * (2 + 16 * 4) + 20, st);
         for (int i = 0; i < k; i++) begin
            check_mon($sformatf("rand_b%0d_mosi%0d", batch, i), exp_tx_q.pop_front());
            bus_read(A_RX, rdat);
            check($sformatf("rand_b%0d_rx%0d", batch, i), rdat, {8'h00, exp_q.pop_front()});
         end
         bus_read(A_ST, rdat);
         check($sformatf("rand_b%0d_status", batch), rdat, 16'h000C);
      end

      // ---------------- TX and RX overflow ----------------
      bus_write(A_DIV, 16'd100);
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         slv_q.push_back(b);
         if (exp_q.size() < 4) exp_q.push_back(b);
      end
      slave_prime();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i < 5) exp_tx_q.push_back(b);
         bus_write(A_TX, {8'h00, b});
      end
      bus_read(A_ST, rdat);   check("txovf_status_first", rdat, 16'h004B);
      bus_read(A_ST, rdat);   check("txovf_status_second", rdat, 16'h000B);
      wait_idle(9000, st);
      check("rxovf_status_at_idle", st, 16'h0034);
      bus_read(A_ST, rdat);   check("rxovf_cleared", rdat, 16'h0014);
      for (int i = 0; i < 5; i++) begin
         check_mon($sformatf("ovf_mosi%0d", i), exp_tx_q.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
         bus_read(A_RX, rdat);
         check($sformatf("ovf_rx%0d", i), rdat, {8'h00, exp_q.pop_front()});
      end
      bus_read(A_RX, rdat);   check("ovf_rx_drained", rdat, 16'h0000);

      // ---------------- RX pop and push in the same cycle ----------------
      bus_write(A_DIV, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         slv_q.push_back(b);
         exp_q.push_back(b);
      end
      slave_prime();
      for (int i = 0; i < 4; i++) bus_write(A_TX, {8'h00, 8'(i + 1)});
      wait_idle(400, st);
      check("simul_rx_full", st, 16'h0014);
      bus_write(A_TX, 16'h0099);
      repeat (18) @(posedge clk);
      bus_read(A_RX, rdat);   check("simul_rx_pop_in_done", rdat, {8'h00, exp_q.pop_front()});
      bus_read(A_ST, rdat);   check("simul_no_ovf", rdat, 16'h0014);
      for (int i = 0; i < 4; i++) begin
         bus_read(A_RX, rdat);
         check($sformatf("simul_rx%0d", i), rdat, {8'h00, exp_q.pop_front()});
      end
      for (int i = 0; i < 4; i++) check_mon($sformatf("simul_mosi%0d", i), 8'(i + 1));
      check_mon("simul_mosi4", 8'h99);

`ifdef SPI_LOOPBACK_EN
      // ---------------- loopback ----------------
      bus_write(A_CTRL, 16'h0002);
      slave_prime();
      bus_write(A_TX, 16'h005A);
      wait_idle(100, st);
      bus_read(A_RX, rdat);   check("loopback_rxdata", rdat, 16'h005A);
      check_mon("loopback_mosi_pin", 8'h5A);
      bus_write(A_CTRL, 16'h0000);
`endif

      // ---------------- reset mid-SHIFT ----------------
      bus_write(A_CTRL, 16'h0000);
      bus_write(A_DIV, 16'd5);
      slv_q.push_back(8'hFF);
      slave_prime();
      bus_write(A_TX, 16'h00FF);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("midreset_sck", {15'h0, sck}, 16'h0000);
      check("midreset_ss_n", {15'h0, ss_n}, 16'h0001);
      check("midreset_mosi", {15'h0, mosi}, 16'h0000);
      rst = 1'b1;
      mon_q.delete(); slv_q.delete(); mon_bits = 0; miso = 1'b0;
      bus_read(A_ST, rdat);   check("midreset_status", rdat, 16'h000C);
      bus_read(A_DIV, rdat);  check("midreset_clkdiv", rdat, 16'h0004);
      repeat (40) @(posedge clk);
      bus_read(A_ST, rdat);   check("midreset_no_rx_push", rdat, 16'h000C);
      bus_read(A_RX, rdat);   check("midreset_rx_empty", rdat, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
